// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The driver uses the master side and the subtractor uses the slave side.
interface serial_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             valid;
  logic             ack;
  logic [WIDTH-1:0] Diff;
  logic             Borrow;
  logic             Ovf;

  modport master (
    output start, A, B, ack,
    input  ready, valid, Diff, Borrow, Ovf
  );

  modport slave (
    input  start, A, B, ack,
    output ready, valid, Diff, Borrow, Ovf
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial A - B, LSB first, one bit per clock with a registered ripple borrow.
// The result, borrow and signed overflow are held in DONE until acknowledged.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  serial_subtractor_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh, d_sh;
  logic [CW-1:0]    cnt;
  logic             c;
  logic             a_msb, b_msb;
  logic             borrow_r, ovf_r;
  logic             ready_c, valid_c;

  // One full-subtractor slice on the current LSBs.
  logic bit_a, bit_b, bit_d, c_nx, last;
  assign bit_a = a_sh[0];
  assign bit_b = b_sh[0];
  assign bit_d = bit_a ^ bit_b ^ c;
  assign c_nx  = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & c);
  assign last  = (cnt == CW'(WIDTH - 1));

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx = state;
    ready_c  = 1'b0;
    valid_c  = 1'b0;
    unique case (state)
      IDLE: begin
        ready_c = 1'b1;
        if (bus.start) state_nx = RUN;
      end
      RUN: begin
        if (last) state_nx = DONE;
      end
      DONE: begin
        valid_c = 1'b1;
        if (bus.ack) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: the datapath is small, so all of it is reset; a reset mid-RUN discards the partial result.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh     <= '0;
      b_sh     <= '0;
      d_sh     <= '0;
      cnt      <= '0;
      c        <= 1'b0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      borrow_r <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            a_sh  <= bus.A;
            b_sh  <= bus.B;
            a_msb <= bus.A[WIDTH-1];
            b_msb <= bus.B[WIDTH-1];
            c     <= 1'b0;
            cnt   <= '0;
          end
        end
        RUN: begin
          d_sh <= {bit_d, d_sh[WIDTH-1:1]};
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          c    <= c_nx;
          cnt  <= cnt + 1'b1;
          // The bit computed on the last step is the result MSB.
          if (last) begin
            borrow_r <= c_nx;
            ovf_r    <= (a_msb != b_msb) && (bit_d != a_msb);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ready  = ready_c;
  assign bus.valid  = valid_c;
  assign bus.Diff   = d_sh;
  assign bus.Borrow = borrow_r;
  assign bus.Ovf    = ovf_r;

endmodule
